comb_gates_100_deser: RTL and testbench

- Upstream feeder for the 100-input reduction-gate stage.
- Accepts narrow CHUNK_NBITS-wide chunks over a val/rdy stream and assembles them LSB-chunk-first into one WORD_NBITS-wide word.
- Presents the assembled word on a val/rdy output whose message drives the 100-bit in_ vector of the AND/NAND/OR/NOR reduction logic.
- Holds the word stable until it is consumed.

---
 rtl/comb_gates_100_deser.sv | 93 +++++++++
 tb/tb_comb_gates_100_deser.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_gates_100_deser.sv
// Chunk deserializer feeding the 100-input reduction-gate stage.
// Collects CHUNK_NBITS chunks LSB-first into a held WORD_NBITS word.
module comb_gates_100_deser #(
  parameter int CHUNK_NBITS = 10,
  parameter int WORD_NBITS  = 100,
  localparam int NUM_CHUNKS = WORD_NBITS / CHUNK_NBITS,
  localparam int CW         = $clog2(NUM_CHUNKS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [CHUNK_NBITS-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [WORD_NBITS-1:0]  out_msg,
  output logic [CW-1:0]          count
);

  if (WORD_NBITS % CHUNK_NBITS != 0) begin : g_bad_width
    $error("WORD_NBITS must be a multiple of CHUNK_NBITS");
  end

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_cnt_nxt;
  logic [WORD_NBITS-1:0]  r_msg;
  logic [WORD_NBITS-1:0]  w_msg_nxt;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  assign in_rdy     = (r_state == FILL) ? 1'b1 : out_rdy;
  assign out_val    = (r_state == FULL);
  assign w_in_xfer  = in_val && in_rdy;
  assign w_out_xfer = out_val && out_rdy;
  assign out_msg    = r_msg;
  assign count      = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_count;
    w_msg_nxt   = r_msg;
    if (clear) begin
      w_state_nxt = FILL;
      w_cnt_nxt   = '0;
      w_msg_nxt   = '0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_in_xfer) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
              if (r_count == CW'(i))
                w_msg_nxt[i*CHUNK_NBITS +: CHUNK_NBITS] = in_msg;
            end
            w_cnt_nxt = r_count + 1'b1;
          end
        end
        FULL: begin
          // Consuming and refilling chunk 0 in one cycle avoids a bubble
          if (w_out_xfer) begin
            if (w_in_xfer) begin
              w_msg_nxt[CHUNK_NBITS-1:0] = in_msg;
              w_cnt_nxt = CW'(1);
            end else begin
              w_cnt_nxt = '0;
            end
          end
        end
      endcase
      w_state_nxt = (w_cnt_nxt == CW'(NUM_CHUNKS)) ? FULL : FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FILL;
      r_count <= '0;
      r_msg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_cnt_nxt;
      r_msg   <= w_msg_nxt;
    end
  end

endmodule

// File: tb/tb_comb_gates_100_deser.sv
// Directed and scoreboard bench for comb_gates_100_deser.
// Each scenario task drives stimulus and checks inline.
module tb_comb_gates_100_deser;

  localparam int CN = 10;
  localparam int WN = 100;
  localparam int NC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_val;
  logic          in_rdy;
  logic [CN-1:0] in_msg;
  logic          out_val;
  logic          out_rdy;
  logic [WN-1:0] out_msg;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comb_gates_100_deser #(
    .CHUNK_NBITS(CN),
    .WORD_NBITS (WN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .in_msg (in_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg),
    .count  (count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset   = 1'b0;
    clear   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in_msg  = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_rdy got %b exp 1", in_rdy);
    end
    checks++;
    if (out_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_val got %b exp 0", out_val);
    end
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", count);
    end
    checks++;
    if (out_msg !== '0) begin
      errors++;
      $display("FAIL reset_out_msg got %h exp 0", out_msg);
    end
  endtask

  task automatic test_stream;
    logic [WN-1:0] exp;
    do_reset();
    exp = {10'd10, 10'd9, 10'd8, 10'd7, 10'd6,
           10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
    out_rdy = 1'b1;
    in_val  = 1'b1;
    for (int i = 0; i < NC; i++) begin
      in_msg = CN'(i + 1);
      #1;
      checks++;
      if (count !== 4'(i) || out_val !== 1'b0) begin
        errors++;
        $display("FAIL stream_count got %0d/%b exp %0d/0",
                 count, out_val, i);
      end
      tick();
    end
    in_val = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b1 || count !== 4'd10) begin
      errors++;
      $display("FAIL stream_full got %b/%0d exp 1/10", out_val, count);
    end
    checks++;
    if (out_msg !== exp) begin
      errors++;
      $display("FAIL stream_word got %h exp %h", out_msg, exp);
    end
    tick();
    checks++;
    if (out_val !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL stream_drain got %b/%0d exp 0/0", out_val, count);
    end
  endtask

  task automatic test_hold;
    do_reset();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_msg  = 10'h3FF;
    for (int i = 0; i < NC; i++) tick();
    in_msg = 10'h000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_val !== 1'b1 || in_rdy !== 1'b0 || count !== 4'd10) begin
        errors++;
        $display("FAIL hold_ctl got v%b r%b c%0d exp v1 r0 c10",
                 out_val, in_rdy, count);
      end
      checks++;
      if (out_msg !== {WN{1'b1}}) begin
        errors++;
        $display("FAIL hold_word got %h exp all ones", out_msg);
      end
      checks++;
      if ((&out_msg) !== 1'b1 || (~|out_msg) !== 1'b0) begin
        errors++;
        $display("FAIL hold_gates got and%b nor%b exp and1 nor0",
                 &out_msg, ~|out_msg);
      end
      tick();
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hold_release_rdy got %b exp 1", in_rdy);
    end
    tick();
    checks++;
    if (out_val !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL hold_consume got %b/%0d exp 0/0", out_val, count);
    end
  endtask

  task automatic test_back_to_back;
    logic [WN-1:0] w1;
    logic [WN-1:0] w2;
    int pulses;
    do_reset();
    pulses = 0;
    for (int k = 0; k < NC; k++) begin
      w1[k*CN +: CN] = CN'(10'h100 + k);
      w2[k*CN +: CN] = CN'(10'h200 + k);
    end
    out_rdy = 1'b1;
    for (int c = 0; c <= 2 * NC; c++) begin
      in_val = (c < 2 * NC);
      in_msg = (c < NC) ? CN'(10'h100 + c) : CN'(10'h200 + c - NC);
      #1;
      if (out_val) pulses++;
      if (c == NC) begin
        checks++;
        if (out_val !== 1'b1 || in_rdy !== 1'b1 || out_msg !== w1) begin
          errors++;
          $display("FAIL b2b_word1 got v%b r%b %h exp v1 r1 %h",
                   out_val, in_rdy, out_msg, w1);
        end
      end
      if (c == NC + 1) begin
        checks++;
        if (count !== 4'd1 || out_val !== 1'b0) begin
          errors++;
          $display("FAIL b2b_refill got c%0d v%b exp c1 v0",
                   count, out_val);
        end
      end
      if (c == 2 * NC) begin
        checks++;
        if (out_val !== 1'b1 || out_msg !== w2) begin
          errors++;
          $display("FAIL b2b_word2 got v%b %h exp v1 %h",
                   out_val, out_msg, w2);
        end
      end
      tick();
    end
    checks++;
    if (out_val !== 1'b0 || pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses got v%b n%0d exp v0 n2", out_val, pulses);
    end
  endtask

  task automatic test_clear;
    do_reset();
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = 10'h155;
    for (int i = 0; i < 4; i++) tick();
    clear  = 1'b1;
    in_msg = 10'h2AA;
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL clear_in_rdy got %b exp 1", in_rdy);
    end
    tick();
    clear  = 1'b0;
    in_val = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || out_msg !== '0 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL clear_partial got c%0d v%b %h exp c0 v0 0",
               count, out_val, out_msg);
    end
    in_val = 1'b1;
    in_msg = 10'h000;
    for (int i = 0; i < NC - 1; i++) tick();
    #1;
    checks++;
    if (count !== 4'd9 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL clear_refill9 got c%0d v%b exp c9 v0", count, out_val);
    end
    tick();
    in_val  = 1'b0;
    out_rdy = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b1 || out_msg !== '0 || (|out_msg) !== 1'b0) begin
      errors++;
      $display("FAIL clear_zero_word got v%b %h exp v1 0", out_val, out_msg);
    end
    clear   = 1'b1;
    out_rdy = 1'b1;
    #1;
    checks++;
    if (out_val !== 1'b1) begin
      errors++;
      $display("FAIL clear_full_val got %b exp 1", out_val);
    end
    tick();
    clear = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL clear_full got v%b c%0d exp v0 c0", out_val, count);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_msg  = 10'h0AB;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b0;
    tick();
    reset  = 1'b1;
    in_val = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || out_val !== 1'b0 || out_msg !== '0
        || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_partial got c%0d v%b r%b %h exp c0 v0 r1 0",
               count, out_val, in_rdy, out_msg);
    end
    in_val = 1'b1;
    in_msg = 10'h3C3;
    for (int i = 0; i < NC; i++) tick();
    in_val = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_full got %b exp 1", out_val);
    end
    reset   = 1'b0;
    out_rdy = 1'b1;
    tick();
    reset   = 1'b1;
    out_rdy = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b0 || count !== 4'd0 || out_msg !== '0) begin
      errors++;
      $display("FAIL rstmid_fullrst got v%b c%0d %h exp v0 c0 0",
               out_val, count, out_msg);
    end
  endtask

  task automatic test_random;
    logic [WN-1:0] m_word;
    logic          m_full;
    logic          e_rdy;
    logic          ix;
    int            m_cnt;
    int            words;
    int            cyc;
    do_reset();
    m_word = '0;
    m_full = 1'b0;
    m_cnt  = 0;
    words  = 0;
    cyc    = 0;
    while (words < 1000 && cyc < 60000) begin
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      in_msg  = CN'($urandom_range(0, 1023));
      #1;
      e_rdy = !m_full || out_rdy;
      checks++;
      if (in_rdy !== e_rdy || out_val !== m_full || count !== 4'(m_cnt)) begin
        errors++;
        $display("FAIL rand_ctl cyc%0d got r%b v%b c%0d exp r%b v%b c%0d",
                 cyc, in_rdy, out_val, count, e_rdy, m_full, m_cnt);
      end
      if (m_full && out_rdy) begin
        checks++;
        if (out_msg !== m_word) begin
          errors++;
          $display("FAIL rand_word %0d got %h exp %h", words, out_msg, m_word);
        end
        words++;
      end
      ix = in_val && e_rdy;
      if (m_full) begin
        if (out_rdy) begin
          m_full = 1'b0;
          m_cnt  = ix ? 1 : 0;
          if (ix) m_word[CN-1:0] = in_msg;
        end
      end else if (ix) begin
        m_word[m_cnt*CN +: CN] = in_msg;
        m_cnt++;
        if (m_cnt == NC) m_full = 1'b1;
      end
      tick();
      cyc++;
    end
    checks++;
    if (words != 1000) begin
      errors++;
      $display("FAIL rand_words got %0d exp 1000", words);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
